// File: rtl/xnor_popcount_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : xnor_popcount_acc                                            |
// | Description : Streaming XNOR match counter. Per-frame saturating sum of    |
// |               equal bit positions, valid/ready on both sides. Define       |
// |               XNOR_POPCOUNT_PIPE_EN to register the popcount before the    |
// |               accumulator (adds a DRAIN state, result latency 2).          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module xnor_popcount_acc #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_eq,
    output logic             out_sat
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef XNOR_POPCOUNT_PIPE_EN
    localparam logic [1:0] S_DRAIN = 2'd3;
`endif

    localparam logic [ACC_W-1:0] C_ACC_MAX  = '1;
    localparam logic [ACC_W-1:0] C_FULL_CNT = ACC_W'(WIDTH);

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_eq;
    logic             r_sat;
    logic [ACC_W-1:0] r_out_sum;
    logic             r_out_eq;
    logic             r_out_sat;

    logic             w_accept;
    logic             w_add_valid;
    logic             w_capture;
    logic [WIDTH-1:0] w_match;
    logic [ACC_W-1:0] w_cnt;
    logic [ACC_W-1:0] w_add_cnt;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_next_acc;
    logic             w_next_eq;
    logic             w_next_sat;

    assign in_ready  = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign out_valid = (r_state == S_HOLD);
    assign out_sum   = r_out_sum;
    assign out_eq    = r_out_eq;
    assign out_sat   = r_out_sat;

    assign w_accept = in_valid & in_ready;
    assign w_match  = ~(a ^ b);

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt = w_cnt + ACC_W'(w_match[i]);
        end
    end

`ifdef XNOR_POPCOUNT_PIPE_EN
    logic             r_p_valid;
    logic [ACC_W-1:0] r_p_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_valid <= 1'b0;
            r_p_cnt   <= '0;
        end else begin
            r_p_valid <= w_accept;
            r_p_cnt   <= w_accept ? w_cnt : '0;
        end
    end

    // The last beat sits in the pipe register while in DRAIN; fold it in there.
    assign w_add_valid = r_p_valid;
    assign w_add_cnt   = r_p_cnt;
    assign w_capture   = (r_state == S_DRAIN);
`else
    assign w_add_valid = w_accept;
    assign w_add_cnt   = w_cnt;
    assign w_capture   = w_accept & in_last;
`endif

    // One extra bit catches the carry so the sum can clamp instead of wrapping.
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_add_cnt};
    assign w_next_acc = w_sum[ACC_W] ? C_ACC_MAX : w_sum[ACC_W-1:0];
    assign w_next_sat = r_sat | w_sum[ACC_W];
    assign w_next_eq  = r_eq & (w_add_cnt == C_FULL_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_eq      <= 1'b1;
            r_sat     <= 1'b0;
            r_out_sum <= '0;
            r_out_eq  <= 1'b0;
            r_out_sat <= 1'b0;
        end else begin
            if (w_capture) begin
                r_out_sum <= w_next_acc;
                r_out_eq  <= w_next_eq;
                r_out_sat <= w_next_sat;
                r_acc     <= '0;
                r_eq      <= 1'b1;
                r_sat     <= 1'b0;
            end else if (w_add_valid) begin
                r_acc <= w_next_acc;
                r_eq  <= w_next_eq;
                r_sat <= w_next_sat;
            end

            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        if (in_last) begin
`ifdef XNOR_POPCOUNT_PIPE_EN
                            r_state <= S_DRAIN;
`else
                            r_state <= S_HOLD;
`endif
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
`ifdef XNOR_POPCOUNT_PIPE_EN
                S_DRAIN: r_state <= S_HOLD;
`endif
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xnor_popcount_acc.sv
`default_nettype none
// Bench for xnor_popcount_acc: two instances (ACC_W=16 and ACC_W=4) share one stimulus
// stream and are compared every cycle against a frame-level reference model.
module tb_xnor_popcount_acc;

    localparam int WIDTH   = 8;
    localparam int ACC_W   = 16;
    localparam int ACC_WS  = 4;
    localparam int C_MAX   = (1 << ACC_W) - 1;
    localparam int C_MAX_S = (1 << ACC_WS) - 1;
`ifdef XNOR_POPCOUNT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_last   = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;

    logic              in_ready, out_valid, out_eq, out_sat;
    logic [ACC_W-1:0]  out_sum;
    logic              in_ready_s, out_valid_s, out_eq_s, out_sat_s;
    logic [ACC_WS-1:0] out_sum_s;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_total;
    bit m_alleq;
    bit m_busy;
    bit m_present;
    int m_wait;
    int e_sum;
    int e_sum_s;
    bit e_eq;
    bit e_sat;
    bit e_sat_s;

    xnor_popcount_acc #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_eq(out_eq), .out_sat(out_sat)
    );

    xnor_popcount_acc #(.WIDTH(WIDTH), .ACC_W(ACC_WS)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_sum(out_sum_s), .out_eq(out_eq_s), .out_sat(out_sat_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_total   = 0;
        m_alleq   = 1'b1;
        m_busy    = 1'b0;
        m_present = 1'b0;
        m_wait    = 0;
    endtask

    task automatic model_step();
        int cnt;
        if (m_present) begin
            if (out_ready) begin
                m_present = 1'b0;
                m_busy    = 1'b0;
            end
        end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) m_present = 1'b1;
        end else if (in_valid) begin
            cnt = $countones(~(a ^ b));
            m_total += cnt;
            if (cnt != WIDTH) m_alleq = 1'b0;
            if (in_last) begin
                e_sum   = (m_total > C_MAX)   ? C_MAX   : m_total;
                e_sat   = (m_total > C_MAX);
                e_sum_s = (m_total > C_MAX_S) ? C_MAX_S : m_total;
                e_sat_s = (m_total > C_MAX_S);
                e_eq    = m_alleq;
                m_total = 0;
                m_alleq = 1'b1;
                m_busy  = 1'b1;
                m_wait  = LAT - 1;
                if (m_wait == 0) m_present = 1'b1;
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_clear();
            else        model_step();
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, !m_busy);
            check("out_valid", out_valid, m_present);
            check("in_ready_s", in_ready_s, !m_busy);
            check("out_valid_s", out_valid_s, m_present);
            if (m_present) begin
                check("out_sum", out_sum, e_sum);
                check("out_eq", out_eq, e_eq);
                check("out_sat", out_sat, e_sat);
                check("out_sum_s", out_sum_s, e_sum_s);
                check("out_eq_s", out_eq_s, e_eq);
                check("out_sat_s", out_sat_s, e_sat_s);
            end
        end
    end

    task automatic beat(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input logic last);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("beat in_ready timeout", in_ready, 1);
        a = aa; b = bb; in_last = last; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int sum, input logic eq, input logic sat,
                                 input int sum_s, input logic sat_s, input bit hs);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " valid"}, out_valid, 1);
        check({tag, " sum"}, out_sum, sum);
        check({tag, " eq"}, out_eq, eq);
        check({tag, " sat"}, out_sat, sat);
        check({tag, " sum_s"}, out_sum_s, sum_s);
        check({tag, " eq_s"}, out_eq_s, eq);
        check({tag, " sat_s"}, out_sat_s, sat_s);
        if (hs) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset out_sum", out_sum, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready after reset", in_ready, 1);

        // Single matching beat
        beat(8'hF0, 8'hF0, 1'b1);
        check("single latency", out_valid, (LAT == 1));
        expect_result("single", 8, 1'b1, 1'b0, 8, 1'b0, 1'b1);

        // Four-beat frame: 0 + 4 + 0 + 8, then held with traffic ignored
        beat(8'h00, 8'hFF, 1'b0);
        beat(8'h0F, 8'h00, 1'b0);
        beat(8'hAA, 8'h55, 1'b0);
        beat(8'hFF, 8'hFF, 1'b1);
        expect_result("frame4", 12, 1'b0, 1'b0, 12, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            in_last = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("hold valid", out_valid, 1);
            check("hold sum", out_sum, 12);
            check("hold ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("released", out_valid, 0);
        beat(8'hFF, 8'hFF, 1'b1);
        expect_result("after hold", 8, 1'b1, 1'b0, 8, 1'b0, 1'b1);

        // Saturation on the narrow instance: 8+8+8 clamps to 15
        beat(8'h3C, 8'h3C, 1'b0);
        beat(8'h3C, 8'h3C, 1'b0);
        beat(8'h3C, 8'h3C, 1'b1);
        expect_result("sat", 24, 1'b1, 1'b0, 15, 1'b1, 1'b1);

        // Partial frame discarded by an asynchronous reset
        beat(8'hFF, 8'hFF, 1'b0);
        beat(8'h0F, 8'h0C, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; a = 8'h12; b = 8'h34; in_last = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async out_valid", out_valid, 0);
        check("async out_sum", out_sum, 0);
        check("async out_sum_s", out_sum_s, 0);
        check("async out_eq", out_eq, 0);
        check("async out_sat", out_sat_s, 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ready after release", in_ready, 1);
        beat(8'h01, 8'h00, 1'b1);
        expect_result("post reset", 7, 1'b0, 1'b0, 7, 1'b0, 1'b1);

        // Randomized traffic with backpressure and one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == 1500) #1 rst_n = 1'b0;
            if (c == 1503) #1 rst_n = 1'b1;
            in_valid = ($urandom_range(0, 3) != 0);
            a = WIDTH'($urandom);
            case ($urandom_range(0, 2))
                0:       b = a;
                1:       b = a ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                default: b = WIDTH'($urandom);
            endcase
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xnor_popcount_acc.md
Name: xnor_popcount_acc

Overview:
- Streaming, parametrised successor to the 2-input XNOR gate.
- Computes bitwise XNOR of two WIDTH-bit operands per beat and popcounts the matches (bits equal).
- Accumulates the count over a frame delimited by in_last, then presents one result per frame.
- Used as the match-count primitive for pattern comparison and binarized dot-product blocks; valid/ready on both sides.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 1.
- ACC_W, 16, accumulator and result width; must be >= clog2(WIDTH+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- in_last  in  1  marks final beat of frame; sampled only on accept.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  ACC_W  saturated total of matching bit positions in frame.
- out_eq  out  1  every bit of every beat in frame matched.
- out_sat  out  1  accumulator saturated during frame.

Behaviour:
- Accept = in_valid & in_ready at a rising edge. Output handshake = out_valid & out_ready.
- Per-beat count is popcount(~(a ^ b)), range 0..WIDTH, zero-extended to ACC_W.
- States:
  - IDLE: acc=0, eq_flag=1, sat_flag=0.
  - ACCUM: at least one beat of the current frame accepted.
  - HOLD: result presented.
- Transitions:
  - IDLE/ACCUM, accept with in_last=0 -> ACCUM.
  - IDLE/ACCUM, accept with in_last=1 -> HOLD.
  - HOLD, output handshake -> IDLE.
- Accumulate: next_acc = acc + count. If the true sum exceeds 2^ACC_W-1, acc clamps to 2^ACC_W-1 and sat_flag sets (sticky for the frame).
- eq_flag clears on any beat with count < WIDTH.
- Result capture: on the accepting edge of the last beat, out_sum/out_eq/out_sat load the final values including that beat. out_valid=1 from the next cycle.
- in_ready = 1 in IDLE and ACCUM; 0 in HOLD. No new frame overlaps a pending result.
- While out_valid=1 and out_ready=0:
  - out_sum, out_eq and out_sat stay stable.
  - in_valid, a, b and in_last are ignored.
- A single-beat frame (in_last=1 on first beat) is legal: result is that beat's count.
- A zero-beat frame is impossible; no result without an accepted beat.
- Result latency: 1 cycle from the accepting edge of the last beat to out_valid (base build).
- Reset values (async assert, synchronous deassert by user):
  - state=IDLE, acc=0, eq_flag=1, sat_flag=0.
  - out_valid=0, out_sum=0, out_eq=0, out_sat=0.
  - in_ready=1 from the first cycle after reset release.
- Reset mid-frame or mid-HOLD discards the partial frame or pending result; the next frame starts from zero.
- out_eq/out_sat/out_sum hold their last values after the output handshake until the next capture; they are only meaningful while out_valid=1.

Optional Feature:
- Macro XNOR_POPCOUNT_PIPE_EN.
- When defined:
  - A register stage is inserted between popcount and accumulator for timing at large WIDTH.
  - Adds a DRAIN state: the last-beat accept moves to DRAIN, then to HOLD on the next edge.
  - out_valid rises 2 cycles after the accepting edge of the last beat.
  - in_ready=0 in DRAIN and HOLD.
  - Pipeline register resets to count 0, valid 0.
- When undefined: no pipeline register, no DRAIN state, latency 1 as above.
- Sums, flags and handshake rules are identical in both builds.

Test Plan:
- Reset asserted mid-cycle with in_valid=1 -> out_valid=0, out_sum=0 immediately; in_ready=1 after release.
- WIDTH=8, single beat a=8'hF0, b=8'hF0, in_last=1 -> next cycle out_valid=1, out_sum=8, out_eq=1, out_sat=0 (2 cycles with XNOR_POPCOUNT_PIPE_EN).
- 4-beat frame (00,FF), (0F,00), (AA,55), (FF,FF, last) -> out_sum=12, out_eq=0, out_sat=0.
- Result pending, out_ready=0 for 5 cycles with in_valid=1 toggling operands -> out_valid stays 1, out_sum stays 12, in_ready=0, no beats counted. Raising out_ready -> IDLE, next frame's sum excludes those beats.
- ACC_W=4, WIDTH=8, three beats a=b=8'h3C, last on third -> out_sum=15, out_sat=1, out_eq=1.
- Two beats (counts 8 and 6) accepted, rst_n pulsed low, then single beat a=8'h01, b=8'h00, last -> out_sum=7, out_eq=0.
